// File: rtl/nebula_wb_pkg.sv
// Shared types and defaults for the Nebula II Wishbone command master.
// Holds the FSM state encoding, default WB widths and the timeout default.
package nebula_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

  localparam int unsigned WB_ADR_W          = 32;
  localparam int unsigned WB_DAT_W          = 32;
  localparam int unsigned WB_SEL_W          = WB_DAT_W / 8;
  localparam int unsigned WB_TIMEOUT_CYCLES = 255;

  // Counter width able to hold 0 .. n-1.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: counts BUS cycles without ack, flags expiry.
// Ports: clk, rst (sync, high), clear, enable -> expire.
module wbm_timeout_ctr
  import nebula_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = ctr_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one cmd -> one WB cycle -> one response.
// Ports: wb_clk_i/wb_rst_i, cmd_* in, rsp_* out, wbm_* WB master side.
// Optional timeout abort under `NEBULA_WBM_TIMEOUT_EN.
module wb_cmd_master
  import nebula_wb_pkg::*;
#(
  parameter int unsigned ADR_W          = WB_ADR_W,
  parameter int unsigned DAT_W          = WB_DAT_W,
  parameter int unsigned SEL_W          = DAT_W / 8,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  wbm_state_e state_q, state_d;
  logic       accept;
  logic       ack_bus;
  logic       expire;

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign ack_bus = (state_q == ST_BUS) && wbm_ack_i;

`ifdef NEBULA_WBM_TIMEOUT_EN
  wbm_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable ((state_q == ST_BUS) && !wbm_ack_i),
    .expire (expire)
  );

  // Ack beats a simultaneous expiry.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_err <= 1'b0;
    end else if (ack_bus) begin
      rsp_err <= 1'b0;
    end else if ((state_q == ST_BUS) && expire) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_BUS;
      ST_BUS:  if (wbm_ack_i || expire) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // WB request fields only load at acceptance, so they stay
  // stable through BUS and keep their last value while idle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat   <= '0;
    end else begin
      if (accept) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
      end
      if (ack_bus) begin
        rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
      end else if ((state_q == ST_BUS) && expire) begin
        rsp_dat <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master.
// Build with +define+NEBULA_WBM_TIMEOUT_EN to exercise the abort path.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dato;
  logic        ack;
  logic [31:0] dati;

  int n_cmp = 0;
  int n_bad = 0;

  wb_cmd_master #(
    .ADR_W(32), .DAT_W(32), .SEL_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dato),
    .wbm_ack_i (ack),
    .wbm_dat_i (dati)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    tick();
    cmd_valid = 1'b0;
    cmd_we    = ~w;
    cmd_adr   = 32'hFFFF_FFFF;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
  endtask

  int          stb_n;
  int          na;
  int          nr;
  int          acc_t[4];
  logic        acc_now;

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 1'b1; ack = 0; dati = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_adr", adr, 0);

    // 1: write, ack in the first BUS cycle
    send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    check("t1_cmd_ready", cmd_ready, 0);
    check("t1_cyc", cyc, 1);
    check("t1_stb", stb, 1);
    check("t1_we", we, 1);
    check("t1_adr", adr, 32'h3000_0004);
    check("t1_dat", dato, 32'hDEAD_BEEF);
    check("t1_sel", sel, 4'hF);
    ack = 1; dati = 32'h1111_1111;
    tick();
    ack = 0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_dat", rsp_dat, 0);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_cyc_drop", cyc, 0);
    tick();
    check("t1_rsp_done", rsp_valid, 0);
    check("t1_ready_back", cmd_ready, 1);

    // 2: read, ack in the 6th BUS cycle
    dati = 32'hAAAA_AAAA;
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    stb_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (stb && adr == 32'h3000_0010 && !we) stb_n++;
      if (i == 5) begin
        ack = 1;
        dati = 32'h1234_5678;
      end
      tick();
    end
    ack = 0; dati = 0;
    check("t2_stb_cycles", stb_n, 6);
    check("t2_stb_drop", stb, 0);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_dat", rsp_dat, 32'h1234_5678);
    tick();

    // 3: response backpressure, new command waits
    rsp_ready = 0;
    send(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    ack = 1; dati = 32'hCAFE_F00D;
    tick();
    ack = 0; dati = 0;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040; cmd_sel = 4'h1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold_valid%0d", i), rsp_valid, 1);
      check($sformatf("t3_hold_dat%0d", i), rsp_dat, 32'hCAFE_F00D);
      check($sformatf("t3_no_accept%0d", i), cmd_ready, 0);
      tick();
    end
    check("t3_still_valid", rsp_valid, 1);
    rsp_ready = 1;
    tick();
    check("t3_rsp_clear", rsp_valid, 0);
    check("t3_idle_ready", cmd_ready, 1);
    check("t3_no_cyc_yet", cyc, 0);
    tick();
    cmd_valid = 0;
    check("t3_new_cyc", cyc, 1);
    check("t3_new_adr", adr, 32'h3000_0040);
    check("t3_new_sel", sel, 4'h1);
    ack = 1; dati = 32'h0000_0042;
    tick();
    ack = 0;
    check("t3_new_rsp", rsp_dat, 32'h0000_0042);
    tick();

`ifdef NEBULA_WBM_TIMEOUT_EN
    // 4: timeout after 8 BUS cycles
    dati = 32'h5555_5555;
    send(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    stb_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (cyc && stb) stb_n++;
      tick();
    end
    check("t4_bus_cycles", stb_n, 8);
    check("t4_cyc_drop", cyc, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_err", rsp_err, 1);
    check("t4_rsp_dat", rsp_dat, 0);
    tick();
    // variant: ack on the expiry cycle wins
    send(1'b0, 32'h3000_0054, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) tick();
    check("t4v_cyc_last", cyc, 1);
    ack = 1; dati = 32'h0000_0077;
    tick();
    ack = 0;
    check("t4v_rsp_valid", rsp_valid, 1);
    check("t4v_rsp_err", rsp_err, 0);
    check("t4v_rsp_dat", rsp_dat, 32'h0000_0077);
    tick();
`else
    // 4: without the timeout the bus waits for ack
    send(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) tick();
    check("t4_still_cyc", cyc, 1);
    check("t4_no_rsp", rsp_valid, 0);
    ack = 1; dati = 32'h0000_0099;
    tick();
    ack = 0;
    check("t4_rsp_err", rsp_err, 0);
    check("t4_rsp_dat", rsp_dat, 32'h0000_0099);
    tick();
`endif

    // 5: reset in BUS cycle 3
    send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick(); tick();
    check("t5_pre_cyc", cyc, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t5_cyc", cyc, 0);
    check("t5_stb", stb, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_adr", adr, 0);
    ack = 1;
    tick();
    ack = 0;
    check("t5_stray_ack", rsp_valid, 0);
    send(1'b1, 32'h3000_0024, 32'h0BAD_F00D, 4'h3);
    check("t5_post_cyc", cyc, 1);
    check("t5_post_dat", dato, 32'h0BAD_F00D);
    check("t5_post_sel", sel, 4'h3);
    ack = 1;
    tick();
    ack = 0;
    check("t5_post_rsp", rsp_valid, 1);
    check("t5_post_dat0", rsp_dat, 0);
    tick();

    // 6: back-to-back reads, slave acks in the first BUS cycle
    na = 0; nr = 0;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h100; cmd_sel = 4'hF;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) begin
        if (nr < 4)
          check($sformatf("t6_rsp%0d", nr), rsp_dat,
                {16'hD00D, 16'h0100 + 16'(4 * nr)});
        nr++;
      end
      ack = stb;
      dati = {16'hD00D, adr[15:0]};
      acc_now = cmd_valid && cmd_ready;
      if (acc_now && na < 4) begin
        acc_t[na] = c;
        na++;
      end
      tick();
      if (acc_now) begin
        if (na >= 4) cmd_valid = 0;
        else cmd_adr = 32'h100 + 32'(4 * na);
      end
    end
    ack = 0;
    check("t6_accepts", na, 4);
    check("t6_responses", nr, 4);
    for (int k = 1; k < 4; k++)
      check($sformatf("t6_gap%0d", k), acc_t[k] - acc_t[k-1], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
